// File: rtl/mips_single_cycle_top.sv
// Single-cycle MIPS subset core with private instruction and data memories.
// One instruction completes per clock; the dmem write bus is exposed on ports.
// imem has no write port: its image is placed in the array before reset is
// released and stays fixed afterwards.
module mips_single_cycle_top #(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata,
    output logic [31:0] dataadr,
    output logic        memwrite
);

    localparam int unsigned IA_W = $clog2(IMEM_WORDS);
    localparam int unsigned DA_W = $clog2(DMEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf   [32];

    logic [31:0] pc, pc_next, pc_plus4, pc_branch, instr;
    logic [31:0] imm_ext, src_a, src_b, rd2, alu_result, readdata, result;
    logic [4:0]  rs, rt, rd, write_reg;
    logic [5:0]  op, funct;
    logic        zero;

    logic    reg_write, mem_write, mem_to_reg, alu_src, reg_dst, branch, jump;
    alu_op_t alu_op;

    assign instr   = imem[pc[IA_W+1:2]];
    assign op      = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign imm_ext = {{16{instr[15]}}, instr[15:0]};

    // Main decoder: anything not recognised falls through as a NOP.
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                reg_dst = 1'b1;
                case (funct)
                    FN_ADD:  begin reg_write = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB:  begin reg_write = 1'b1; alu_op = ALU_SUB; end
                    FN_AND:  begin reg_write = 1'b1; alu_op = ALU_AND; end
                    FN_OR:   begin reg_write = 1'b1; alu_op = ALU_OR;  end
                    FN_SLT:  begin reg_write = 1'b1; alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; end
            OP_SW:   begin mem_write = 1'b1; alu_src = 1'b1; end
            OP_BEQ:  begin branch = 1'b1; alu_op = ALU_SUB; end
            OP_ADDI: begin reg_write = 1'b1; alu_src = 1'b1; end
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    assign src_a = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rd2   = (rt == 5'd0) ? 32'd0 : rf[rt];
    assign src_b = alu_src ? imm_ext : rd2;

    // ALU: 32-bit modulo arithmetic, signed set-less-than.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_result = 32'd0;
        endcase
    end

    assign zero      = (alu_result == 32'd0);
    assign pc_plus4  = pc + 32'd4;
    assign pc_branch = pc_plus4 + {imm_ext[29:0], 2'b00};

    // Next PC: jump, then taken branch, otherwise sequential.
    always_comb begin
        pc_next = pc_plus4;
        if (jump)
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch && zero)
            pc_next = pc_branch;
    end

    // Program counter.
    always_ff @(posedge clk) begin
        if (reset) pc <= 32'd0;
        else       pc <= pc_next;
    end

    assign write_reg = reg_dst ? rd : rt;
    assign readdata  = dmem[dataadr[DA_W+1:2]];
    assign result    = mem_to_reg ? readdata : alu_result;

    // Register file write; $0 is hard-wired and reset suppresses writes.
    always_ff @(posedge clk) begin
        if (!reset && reg_write && (write_reg != 5'd0))
            rf[write_reg] <= result;
    end

    assign dataadr   = alu_result;
    assign writedata = rd2;
    assign memwrite  = mem_write & ~reset;

    // Data memory write; upper address bits are ignored so addresses wrap.
    always_ff @(posedge clk) begin
        if (memwrite)
            dmem[dataadr[DA_W+1:2]] <= writedata;
    end

endmodule

// File: tb/tb_mips_single_cycle_top.sv
// Bench for mips_single_cycle_top: loads small programs into imem, predicts
// every store and checks the dmem write bus against a scoreboard.
module tb_mips_single_cycle_top;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] writedata, dataadr;
    logic        memwrite;

    mips_single_cycle_top dut (
        .clk       (clk),
        .reset     (reset),
        .writedata (writedata),
        .dataadr   (dataadr),
        .memwrite  (memwrite)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } store_t;

    store_t      sb [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] prog [64];
    int          wp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    task automatic emit(input logic [31:0] w);
        prog[wp] = w;
        wp++;
    endtask

    task automatic halt();
        emit({6'h02, 26'(wp)});
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        wp = 0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];
    endtask

    task automatic expect_store(input logic [31:0] adr, input logic [31:0] data);
        sb.push_back({adr, data});
    endtask

    // Enter reset; program may be loaded while it is held.
    task automatic enter_reset();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic leave_reset(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check(tag, dut.pc, 32'd0);
        reset = 1'b0;
    endtask

    task automatic drained(input string tag);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // Store monitor: sampled on the falling edge, away from state updates.
    always @(negedge clk) begin : mon
        store_t e;
        if (reset) begin
            check("memwrite_in_reset", 32'(memwrite), 32'd0);
        end else if (memwrite === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_store_adr", dataadr, 32'hxxxxxxxx);
            end else begin
                e = sb.pop_front();
                check("store_adr", dataadr, e.adr);
                check("store_data", writedata, e.data);
            end
        end
    end

    task automatic build_main();
        clear_prog();
        emit(enc_i(8'h08, 0, 2, 16'd5));
        emit(enc_i(8'h08, 0, 3, 16'd12));
        emit(enc_i(8'h08, 3, 7, 16'hFFF7));
        emit(enc_r(7, 2, 4, 8'h25));
        emit(enc_r(3, 4, 5, 8'h24));
        emit(enc_r(5, 4, 5, 8'h20));
        emit(enc_i(8'h04, 5, 7, 16'd10));
        emit(enc_r(3, 4, 4, 8'h2A));
        emit(enc_i(8'h04, 4, 0, 16'd1));
        emit(enc_i(8'h08, 0, 5, 16'd0));
        emit(enc_r(7, 2, 4, 8'h2A));
        emit(enc_r(4, 5, 7, 8'h20));
        emit(enc_r(7, 2, 7, 8'h22));
        emit(enc_i(8'h2B, 3, 7, 16'd68));
        emit(enc_i(8'h23, 0, 2, 16'd80));
        emit({6'h02, 26'd17});
        emit(enc_i(8'h08, 0, 2, 16'd1));
        emit(enc_i(8'h2B, 0, 2, 16'd84));
        halt();
    endtask

    initial begin
        reset = 1'b1;

        // Main program, full run.
        build_main();
        load_prog();
        expect_store(32'd80, 32'd7);
        expect_store(32'd84, 32'd7);
        leave_reset("pc_after_reset");
        repeat (20) @(posedge clk);
        #1;
        check("main_halt_pc", dut.pc, 32'd72);
        drained("main_stores");

        // Reset at the 5th instruction, then re-execute.
        expect_store(32'd80, 32'd7);
        expect_store(32'd84, 32'd7);
        enter_reset();
        leave_reset("pc_rerun_reset");
        repeat (4) @(posedge clk);
        #1;
        check("pc_at_5th", dut.pc, 32'd16);
        reset = 1'b1;
        @(posedge clk); #1;
        check("pc_mid_reset", dut.pc, 32'd0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        drained("mid_reset_stores");

        // Reset while a sw is current: the store must be suppressed.
        expect_store(32'd80, 32'd7);
        expect_store(32'd84, 32'd7);
        enter_reset();
        leave_reset("pc_sw_reset");
        repeat (12) @(posedge clk);
        #1;
        check("pc_at_sw", dut.pc, 32'd52);
        check("memwrite_at_sw", 32'(memwrite), 32'd1);
        reset = 1'b1;
        #1;
        check("memwrite_forced_0", 32'(memwrite), 32'd0);
        @(posedge clk); #1;
        check("pc_after_sw_reset", dut.pc, 32'd0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        drained("sw_reset_stores");

        // Branch program: taken beq skips two sw, untaken beq falls through.
        enter_reset();
        clear_prog();
        emit(enc_i(8'h08, 0, 1, 16'd3));
        emit(enc_i(8'h04, 1, 1, 16'd2));
        emit(enc_i(8'h2B, 0, 1, 16'd0));
        emit(enc_i(8'h2B, 0, 1, 16'd4));
        emit(enc_i(8'h08, 0, 2, 16'd4));
        emit(enc_i(8'h04, 1, 2, 16'd1));
        emit(enc_i(8'h2B, 0, 2, 16'd8));
        halt();
        load_prog();
        expect_store(32'd8, 32'd4);
        leave_reset("pc_branch_reset");
        begin
            logic [31:0] pcs [6];
            pcs = '{32'd4, 32'd16, 32'd20, 32'd24, 32'd28, 32'd28};
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                check($sformatf("branch_pc%0d", i), dut.pc, pcs[i]);
            end
        end
        drained("branch_stores");

        // ALU corner cases, $0, NOP encodings and address wrap.
        enter_reset();
        clear_prog();
        emit(enc_i(8'h08, 0, 2, 16'h8000));
        for (int i = 0; i < 16; i++) emit(enc_r(2, 2, 2, 8'h20));
        emit(enc_i(8'h08, 2, 1, 16'hFFFF));
        emit(enc_i(8'h08, 0, 2, 16'd1));
        emit(enc_r(1, 2, 3, 8'h20));
        emit(enc_i(8'h2B, 0, 3, 16'd0));
        expect_store(32'd0, 32'h8000_0000);
        emit(enc_i(8'h08, 0, 4, 16'd5));
        emit(enc_i(8'h08, 0, 5, 16'd12));
        emit(enc_r(4, 5, 6, 8'h22));
        emit(enc_i(8'h2B, 0, 6, 16'd4));
        expect_store(32'd4, 32'hFFFF_FFF9);
        emit(enc_i(8'h08, 0, 7, 16'hFFFF));
        emit(enc_r(7, 2, 8, 8'h2A));
        emit(enc_i(8'h2B, 0, 8, 16'd8));
        expect_store(32'd8, 32'd1);
        emit(enc_r(2, 7, 9, 8'h2A));
        emit(enc_i(8'h2B, 0, 9, 16'd12));
        expect_store(32'd12, 32'd0);
        emit(enc_i(8'h08, 0, 10, 16'h7878));
        emit(enc_r(10, 10, 10, 8'h20));
        emit(enc_i(8'h08, 0, 11, 16'h0FF0));
        emit(enc_r(10, 11, 12, 8'h24));
        emit(enc_i(8'h2B, 0, 12, 16'd16));
        expect_store(32'd16, 32'h0000_00F0);
        emit(enc_r(10, 11, 13, 8'h25));
        emit(enc_i(8'h2B, 0, 13, 16'd20));
        expect_store(32'd20, 32'h0000_FFF0);
        emit(enc_i(8'h08, 0, 0, 16'd9));
        emit(enc_i(8'h2B, 0, 0, 16'd0));
        expect_store(32'd0, 32'd0);
        emit(enc_i(8'h29, 0, 3, 16'd32));
        emit(enc_r(1, 2, 3, 8'h00));
        emit(enc_i(8'h2B, 0, 3, 16'd28));
        expect_store(32'd28, 32'h8000_0000);
        emit(enc_i(8'h2B, 0, 4, 16'd288));
        expect_store(32'd288, 32'd5);
        emit(enc_i(8'h23, 0, 14, 16'd32));
        emit(enc_i(8'h2B, 0, 14, 16'd36));
        expect_store(32'd36, 32'd5);
        halt();
        load_prog();
        leave_reset("pc_alu_reset");
        repeat (50) @(posedge clk);
        #1;
        drained("alu_stores");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
